// File: rtl/datamover_pkg.sv
// Shared definitions for the inbound and outbound packet movers:
// FSM states, packet length limits, descriptor layout and last-beat keep helper.
package datamover_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int LEN_W  = 16;
    localparam int BEAT_W = 9;

    localparam logic [LEN_W-1:0] LEN_MIN = 16'd16;
    localparam logic [LEN_W-1:0] LEN_MAX = 16'd1600;

    // Descriptor: {length[15:0], address[ADDR_WIDTH-1:0]}
    localparam int DESC_ADDR_LSB = 0;

    function automatic int desc_len_lsb(input int addr_width);
        return addr_width;
    endfunction

    // One bit of the final-beat tkeep: low (len mod bpb) lanes, or all lanes on a whole beat.
    function automatic logic last_keep_bit(input logic [LEN_W-1:0] len, input int bpb, input int idx);
        int rem;
        rem = int'(len) % bpb;
        return (rem == 0) || (idx < rem);
    endfunction

endpackage

// File: rtl/datamover_burst_calc.sv
// Burst sizing: the smallest of MAX_BURST, the beats still owed, and the beats
// left before the next 4 KB boundary.
module datamover_burst_calc
    import datamover_pkg::*;
#(
    parameter int BPB       = 4,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0]       addr_lo,
    input  logic [BEAT_W-1:0] remaining,
    output logic [BEAT_W-1:0] burst_beats,
    output logic [7:0]        arlen
);

    localparam int LOG_BPB = $clog2(BPB);

    logic [12:0] dist_4k;
    logic [12:0] lim;

    always_comb begin
        dist_4k = (13'd4096 - {1'b0, addr_lo}) >> LOG_BPB;
        lim     = 13'(MAX_BURST);
        if (13'(remaining) < lim) lim = 13'(remaining);
        if (dist_4k < lim) lim = dist_4k;
        burst_beats = BEAT_W'(lim);
        arlen       = 8'(lim - 13'd1);
    end

endmodule

// File: rtl/datamover_out.sv
// Memory-to-stream mover: takes {len, addr} descriptors, reads the buffer with
// INCR bursts and forwards R beats straight onto the output stream.
module datamover_out
    import datamover_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH+15:0]  s_desc_tdata,
    input  logic                    s_desc_tvalid,
    output logic                    s_desc_tready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [DATA_WIDTH-1:0]   axi_stream_out_tdata,
    output logic [DATA_WIDTH/8-1:0] axi_stream_out_tkeep,
    output logic                    axi_stream_out_tlast,
    output logic                    axi_stream_out_tvalid,
    input  logic                    axi_stream_out_tready,
    output logic [1:0]              err_status,
    output logic [1:0]              dbg_state
);

    localparam int BPB     = DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int LEN_LSB = desc_len_lsb(ADDR_WIDTH);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never waits on ready, and payload is held stable while valid is high.

    state_t                state, state_nx;
    logic                  init_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [BEAT_W-1:0]     remaining;
    logic [BEAT_W-1:0]     burst_left;
    logic [BEAT_W-1:0]     calc_beats;
    logic [7:0]            calc_arlen;
    logic [1:0]            err_q;
    logic [BPB-1:0]        keep_last;
    logic [LEN_W-1:0]      desc_len;
    logic [LEN_W:0]        len_round;
    logic                  desc_ok;
    logic                  desc_fire;
    logic                  beat_fire;
    logic                  final_beat;
    logic                  burst_end;

    assign desc_len   = s_desc_tdata[LEN_LSB +: LEN_W];
    assign len_round  = {1'b0, desc_len} + (LEN_W+1)'(BPB - 1);
    assign desc_ok    = (desc_len >= LEN_MIN) && (desc_len <= LEN_MAX);
    assign desc_fire  = (state == IDLE) && init_q && s_desc_tvalid;
    assign beat_fire  = (state == DATA) && m_rvalid && axi_stream_out_tready;
    assign final_beat = (remaining == BEAT_W'(1));
    assign burst_end  = (burst_left == BEAT_W'(1));

    assign m_araddr   = addr_q;
    assign m_arsize   = 3'(LOG_BPB);
    assign m_arburst  = 2'b01;
    assign err_status = err_q;
    assign dbg_state  = state;

    datamover_burst_calc #(
        .BPB       (BPB),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr_lo     (addr_q[11:0]),
        .remaining   (remaining),
        .burst_beats (calc_beats),
        .arlen       (calc_arlen)
    );

    always_comb begin
        for (int i = 0; i < BPB; i++) keep_last[i] = last_keep_bit(len_q, BPB, i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx              = state;
        s_desc_tready         = 1'b0;
        m_arvalid             = 1'b0;
        m_arlen               = 8'd0;
        m_rready              = 1'b0;
        axi_stream_out_tdata  = '0;
        axi_stream_out_tkeep  = '0;
        axi_stream_out_tlast  = 1'b0;
        axi_stream_out_tvalid = 1'b0;
        case (state)
            IDLE: begin
                s_desc_tready = init_q;
                if (desc_fire && desc_ok) state_nx = ADDR;
            end
            ADDR: begin
                m_arvalid = 1'b1;
                m_arlen   = calc_arlen;
                if (m_arready) state_nx = DATA;
            end
            DATA: begin
                m_rready              = axi_stream_out_tready;
                axi_stream_out_tdata  = m_rdata;
                axi_stream_out_tvalid = m_rvalid;
                axi_stream_out_tlast  = final_beat;
                axi_stream_out_tkeep  = final_beat ? keep_last : '1;
                if (beat_fire && burst_end) state_nx = final_beat ? IDLE : ADDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Burst end follows the beat counter; rlast is only cross-checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            remaining  <= '0;
            burst_left <= '0;
            err_q      <= 2'b00;
        end else begin
            init_q <= 1'b1;
            if (desc_fire) begin
                if (desc_ok) begin
                    addr_q    <= s_desc_tdata[DESC_ADDR_LSB +: ADDR_WIDTH];
                    len_q     <= desc_len;
                    remaining <= BEAT_W'(len_round >> LOG_BPB);
                end else begin
                    err_q[0] <= 1'b1;
                end
            end
            if (state == ADDR && m_arready) burst_left <= calc_beats;
            if (beat_fire) begin
                addr_q     <= addr_q + ADDR_WIDTH'(BPB);
                remaining  <= remaining - BEAT_W'(1);
                burst_left <= burst_left - BEAT_W'(1);
                if (m_rresp != 2'b00 || m_rlast != burst_end) err_q[1] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_datamover_out.sv
// Directed bench for datamover_out: acts as the AXI read slave and the stream
// sink, checking AR fields, pass-through data, tkeep/tlast and error flags.
module tb_datamover_out;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW+15:0] s_desc_tdata;
    logic          s_desc_tvalid;
    logic          s_desc_tready;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic [DW-1:0] tdata;
    logic [3:0]    tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [1:0]    err_status;
    logic [1:0]    dbg_state;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            beat_no;
    int            total_beats;
    logic [3:0]    last_keep_exp;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    datamover_out #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .s_desc_tdata          (s_desc_tdata),
        .s_desc_tvalid         (s_desc_tvalid),
        .s_desc_tready         (s_desc_tready),
        .m_araddr              (m_araddr),
        .m_arlen               (m_arlen),
        .m_arsize              (m_arsize),
        .m_arburst             (m_arburst),
        .m_arvalid             (m_arvalid),
        .m_arready             (m_arready),
        .m_rdata               (m_rdata),
        .m_rresp               (m_rresp),
        .m_rlast               (m_rlast),
        .m_rvalid              (m_rvalid),
        .m_rready              (m_rready),
        .axi_stream_out_tdata  (tdata),
        .axi_stream_out_tkeep  (tkeep),
        .axi_stream_out_tlast  (tlast),
        .axi_stream_out_tvalid (tvalid),
        .axi_stream_out_tready (tready),
        .err_status            (err_status),
        .dbg_state             (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at negedge+1; returns at negedge+1 after the handshake cycle.
    task automatic send_desc(input logic [31:0] addr, input logic [15:0] len, input bit accept);
        int n;
        n = 0;
        s_desc_tdata  = {len, addr};
        s_desc_tvalid = 1'b1;
        #1;
        while (!s_desc_tready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("desc_ready_wait", 64'(n < 20), 64'd1);
        @(negedge clk);
        s_desc_tvalid = 1'b0;
        #1;
        check("arvalid_after_desc", 64'(m_arvalid), 64'(accept));
        check("desc_ready_after", 64'(s_desc_tready), 64'(!accept));
    endtask

    task automatic ar_expect(input logic [31:0] addr, input logic [7:0] len);
        check("arvalid", 64'(m_arvalid), 64'd1);
        check("araddr", 64'(m_araddr), 64'(addr));
        check("arlen", 64'(m_arlen), 64'(len));
        check("arsize", 64'(m_arsize), 64'd2);
        check("arburst", 64'(m_arburst), 64'd1);
        check("desc_ready_busy", 64'(s_desc_tready), 64'd0);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        #1;
        check("arvalid_drop", 64'(m_arvalid), 64'd0);
    endtask

    task automatic r_burst(input int n, input int err_idx, input bit rnd);
        bit taken;
        int tries;
        logic [3:0] keep_e;
        logic       last_e;
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hC0DE_0000 + 32'(beat_no);
            m_rlast  = (i == n - 1);
            m_rresp  = (beat_no == err_idx) ? 2'b10 : 2'b00;
            exp_q.push_back(m_rdata);
            last_e = (beat_no == total_beats - 1);
            keep_e = last_e ? last_keep_exp : 4'hF;
            taken  = 1'b0;
            tries  = 0;
            while (!taken) begin
                tready = (rnd && tries < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                check("rready_follows_tready", 64'(m_rready), 64'(tready));
                check("tvalid", 64'(tvalid), 64'd1);
                if (tready) begin
                    check("tdata", 64'(tdata), 64'(exp_q.pop_front()));
                    check("tkeep", 64'(tkeep), 64'(keep_e));
                    check("tlast", 64'(tlast), 64'(last_e));
                    taken = 1'b1;
                end
                @(negedge clk);
                tries++;
            end
            beat_no++;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        tready   = 1'b0;
        #1;
        check("tvalid_idle", 64'(tvalid), 64'd0);
    endtask

    task automatic start_packet(input int beats, input logic [3:0] keep);
        beat_no       = 0;
        total_beats   = beats;
        last_keep_exp = keep;
    endtask

    task automatic packet_done();
        check("desc_ready_after_final", 64'(s_desc_tready), 64'd1);
        check("state_idle", 64'(dbg_state), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_desc_tdata = '0; s_desc_tvalid = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_desc_ready", 64'(s_desc_tready), 64'd0);
        check("rst_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_araddr", 64'(m_araddr), 64'd0);
        check("rst_arlen", 64'(m_arlen), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'd0);
        check("rst_rready", 64'(m_rready), 64'd0);
        check("rst_err", 64'(err_status), 64'd0);
        rst_n = 1'b1;
        #1;
        check("desc_ready_before_clk", 64'(s_desc_tready), 64'd0);
        @(negedge clk); #1;
        check("desc_ready_after_release", 64'(s_desc_tready), 64'd1);

        // len=16 @0x1000: one burst of 4 full beats
        start_packet(4, 4'hF);
        send_desc(32'h0000_1000, 16'd16, 1'b1);
        ar_expect(32'h0000_1000, 8'd3);
        r_burst(4, -1, 1'b0);
        packet_done();

        // len=17 @0x2000: 5 beats, one byte valid on the last
        start_packet(5, 4'b0001);
        send_desc(32'h0000_2000, 16'd17, 1'b1);
        ar_expect(32'h0000_2000, 8'd4);
        r_burst(5, -1, 1'b0);
        packet_done();

        // len=1600 @0x10000: 25 bursts of 16 beats
        start_packet(400, 4'hF);
        send_desc(32'h0001_0000, 16'd1600, 1'b1);
        for (int b = 0; b < 25; b++) begin
            ar_expect(32'h0001_0000 + 32'(b * 64), 8'd15);
            r_burst(16, -1, 1'b0);
        end
        packet_done();

        // 4 KB crossing: 0xFF8 len=32 splits into 2 + 6 beats
        start_packet(8, 4'hF);
        send_desc(32'h0000_0FF8, 16'd32, 1'b1);
        ar_expect(32'h0000_0FF8, 8'd1);
        r_burst(2, -1, 1'b0);
        ar_expect(32'h0000_1000, 8'd5);
        r_burst(6, -1, 1'b0);
        packet_done();
        check("err_clean", 64'(err_status), 64'd0);

        // Random backpressure with SLVERR on beat 2
        start_packet(6, 4'hF);
        send_desc(32'h0000_5000, 16'd24, 1'b1);
        ar_expect(32'h0000_5000, 8'd5);
        r_burst(6, 1, 1'b1);
        packet_done();
        check("err_slverr", 64'(err_status), 64'b10);

        // Reset in the middle of DATA
        start_packet(16, 4'hF);
        send_desc(32'h0000_6000, 16'd64, 1'b1);
        ar_expect(32'h0000_6000, 8'd15);
        r_burst(3, -1, 1'b0);
        m_rvalid = 1'b1;
        tready   = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_arvalid", 64'(m_arvalid), 64'd0);
        check("midrst_rready", 64'(m_rready), 64'd0);
        check("midrst_desc_ready", 64'(s_desc_tready), 64'd0);
        check("midrst_araddr", 64'(m_araddr), 64'd0);
        check("midrst_err", 64'(err_status), 64'd0);
        m_rvalid = 1'b0;
        tready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        start_packet(4, 4'hF);
        send_desc(32'h0000_3000, 16'd16, 1'b1);
        ar_expect(32'h0000_3000, 8'd3);
        r_burst(4, -1, 1'b0);
        packet_done();

        // Out-of-range lengths are dropped without any AR
        send_desc(32'h0000_4000, 16'd8, 1'b0);
        check("drop8_err", 64'(err_status), 64'b01);
        @(negedge clk); #1;
        check("drop8_no_ar", 64'(m_arvalid), 64'd0);
        send_desc(32'h0000_4000, 16'd1601, 1'b0);
        check("drop1601_err", 64'(err_status), 64'b01);
        check("drop1601_idle", 64'(dbg_state), 64'd0);

        start_packet(5, 4'hF);
        send_desc(32'h0000_7000, 16'd20, 1'b1);
        ar_expect(32'h0000_7000, 8'd4);
        r_burst(5, -1, 1'b0);
        packet_done();
        check("err_sticky", 64'(err_status), 64'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
